// File: rtl/pmod_pkg.sv
// ============================================================================
// pmod_pkg : shared types and default constants for Pmod input conditioning
// Revision  : 1.0
// ============================================================================
`default_nettype none

package pmod_pkg;

    typedef enum logic [1:0] {
        STABLE_LO = 2'd0,
        WAIT_HI   = 2'd1,
        STABLE_HI = 2'd2,
        WAIT_LO   = 2'd3
    } pmod_state_t;

    localparam int CLK_HZ              = 50_000_000;
    localparam int DEBOUNCE_MS         = 10;
    localparam int DEFAULT_SYNC_STAGES = 2;

    function automatic int debounce_cycles(input int clk_hz, input int ms);
        return (clk_hz / 1000) * ms;
    endfunction

    localparam int DEFAULT_DEBOUNCE_CYCLES = debounce_cycles(CLK_HZ, DEBOUNCE_MS);

endpackage

`default_nettype wire

// File: rtl/pmod_sync.sv
// ============================================================================
// pmod_sync : SYNC_STAGES-deep flop chain bringing an async pin into clk domain
// Revision  : 1.0
// ============================================================================
`default_nettype none

module pmod_sync
    import pmod_pkg::*;
#(
    parameter int SYNC_STAGES = DEFAULT_SYNC_STAGES
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic [SYNC_STAGES-1:0] sync_r;

    // Pure flop chain: nothing may sit between stages or metastability
    // resolution time is eaten by logic delay.
    generate
        for (genvar i = 0; i < SYNC_STAGES; i++) begin : g_stage
            if (i == 0) begin : g_first
                always_ff @(posedge clk or negedge rst_n) begin
                    if (!rst_n) sync_r[0] <= 1'b0;
                    else        sync_r[0] <= d;
                end
            end else begin : g_next
                always_ff @(posedge clk or negedge rst_n) begin
                    if (!rst_n) sync_r[i] <= 1'b0;
                    else        sync_r[i] <= sync_r[i-1];
                end
            end
        end
    endgenerate

    assign q = sync_r[SYNC_STAGES-1];

endmodule

`default_nettype wire

// File: rtl/pmod_input_conditioner.sv
// ============================================================================
// pmod_input_conditioner : synchronise + debounce a Pmod pin; level, strobes, toggle
// Revision  : 1.0
// ============================================================================
`default_nettype none

module pmod_input_conditioner
    import pmod_pkg::*;
#(
    parameter int SYNC_STAGES     = DEFAULT_SYNC_STAGES,
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
    input  logic clk,
    input  logic rst_n,
    input  logic pin_in,
    output logic level_out,
    output logic rise_pulse,
    output logic fall_pulse,
    output logic toggle_out
);

    localparam int               CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam bit               SINGLE   = (DEBOUNCE_CYCLES == 1);

    logic             s;
    pmod_state_t      state;
    logic [CNT_W-1:0] cnt;

    pmod_sync #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_sync (
        .clk  (clk),
        .rst_n(rst_n),
        .d    (pin_in),
        .q    (s)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= STABLE_LO;
            cnt        <= '0;
            level_out  <= 1'b0;
            rise_pulse <= 1'b0;
            fall_pulse <= 1'b0;
            toggle_out <= 1'b0;
        end else begin
            rise_pulse <= 1'b0;
            fall_pulse <= 1'b0;
            case (state)
                STABLE_LO: begin
                    if (s && SINGLE) begin
                        state      <= STABLE_HI;
                        cnt        <= '0;
                        level_out  <= 1'b1;
                        rise_pulse <= 1'b1;
                        toggle_out <= ~toggle_out;
                    end else if (s) begin
                        state <= WAIT_HI;
                        cnt   <= CNT_ONE;
                    end else begin
                        cnt <= '0;
                    end
                end
                WAIT_HI: begin
                    if (!s) begin
                        state <= STABLE_LO;
                        cnt   <= '0;
                    end else if (cnt == CNT_LAST) begin
                        state      <= STABLE_HI;
                        cnt        <= '0;
                        level_out  <= 1'b1;
                        rise_pulse <= 1'b1;
                        toggle_out <= ~toggle_out;
                    end else begin
                        cnt <= cnt + CNT_ONE;
                    end
                end
                STABLE_HI: begin
                    if (!s && SINGLE) begin
                        state      <= STABLE_LO;
                        cnt        <= '0;
                        level_out  <= 1'b0;
                        fall_pulse <= 1'b1;
                    end else if (!s) begin
                        state <= WAIT_LO;
                        cnt   <= CNT_ONE;
                    end else begin
                        cnt <= '0;
                    end
                end
                WAIT_LO: begin
                    if (s) begin
                        state <= STABLE_HI;
                        cnt   <= '0;
                    end else if (cnt == CNT_LAST) begin
                        state      <= STABLE_LO;
                        cnt        <= '0;
                        level_out  <= 1'b0;
                        fall_pulse <= 1'b1;
                    end else begin
                        cnt <= cnt + CNT_ONE;
                    end
                end
                default: begin
                    state <= STABLE_LO;
                    cnt   <= '0;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: doc/pmod_input_conditioner.md
Name: pmod_input_conditioner

Overview:
- Upstream stage for the Pmod-to-LED passthrough path. Conditions a raw, asynchronous Pmod header input before it drives LED logic.
- Synchronises the pin into the system clock domain and debounces it.
- Outputs a clean level, single-cycle rise/fall strobes, and a toggle bit. The downstream LED stage consumes the clean level (or the toggle) in place of the raw pin.

Parameters:
- SYNC_STAGES, 2, number of flops in the synchroniser chain; legal range 2..4.
- DEBOUNCE_CYCLES, 500000, consecutive clocks the synchronised input must hold a new value before it is accepted (10 ms at 50 MHz); must be >= 1.
- CNT_W, $clog2(DEBOUNCE_CYCLES+1), debounce counter width; derived, not overridden.

Ports:
- clk  input  1  system clock; all state is on the rising edge.
- rst_n  input  1  asynchronous active-low reset; assertion is asynchronous, deassertion is used synchronously to clk.
- pin_in  input  1  raw Pmod pin, asynchronous to clk.
- level_out  output  1  debounced level, registered.
- rise_pulse  output  1  one-cycle strobe when level_out goes 0->1.
- fall_pulse  output  1  one-cycle strobe when level_out goes 1->0.
- toggle_out  output  1  inverts on every accepted rising edge.

Behaviour:
- Reset values:
  - synchroniser flops 0, counter 0, state STABLE_LO.
  - level_out 0, rise_pulse 0, fall_pulse 0, toggle_out 0.
- Synchroniser:
  - pin_in passes through SYNC_STAGES flops; s is the last flop.
  - No logic between the stages.
- State machine (4 states): STABLE_LO, WAIT_HI, STABLE_HI, WAIT_LO.
  - STABLE_LO:
    - s==1 and DEBOUNCE_CYCLES==1: go directly to STABLE_HI with acceptance actions.
    - s==1 otherwise: go to WAIT_HI, cnt<=1.
    - s==0: stay, cnt<=0.
  - WAIT_HI:
    - s==0: return to STABLE_LO, cnt<=0 (glitch rejected, no output change).
    - s==1 and cnt==DEBOUNCE_CYCLES-1: go to STABLE_HI, cnt<=0, level_out<=1, rise_pulse<=1, toggle_out<=~toggle_out.
    - otherwise cnt<=cnt+1.
  - STABLE_HI and WAIT_LO mirror the above with polarity swapped. Acceptance sets level_out<=0 and fall_pulse<=1; toggle_out is unchanged.
- Pulses:
  - rise_pulse and fall_pulse are 0 in every cycle other than the acceptance cycle.
  - They are never high together.
- Latency: level_out changes SYNC_STAGES+DEBOUNCE_CYCLES-1 edges after the edge that first samples the new pin value. The pin must stay stable throughout.
- Counter:
  - Saturation is not needed; cnt never exceeds DEBOUNCE_CYCLES-1.
  - No wrap-around is possible.
- Glitch rule: any pulse on s shorter than DEBOUNCE_CYCLES consecutive cycles produces no change on any output.
- Reset mid-operation:
  - Asserting rst_n low in any state immediately forces all reset values.
  - A debounce in progress is discarded.
  - After release the block restarts from STABLE_LO, even if the pin is high. A high pin is then accepted after the normal latency and produces rise_pulse.

Decomposition:
- Shared package pmod_pkg:
  - state enum (STABLE_LO, WAIT_HI, STABLE_HI, WAIT_LO).
  - default constants CLK_HZ=50_000_000, DEBOUNCE_MS=10, DEFAULT_SYNC_STAGES=2.
- Sub-module pmod_sync: parameterised SYNC_STAGES-deep synchroniser with the same clk/rst_n. It is reused for other Pmod inputs on the board.
- FSM and counter remain in pmod_input_conditioner.

Test Plan (SYNC_STAGES=2, DEBOUNCE_CYCLES=4 unless stated):
- Reset: hold rst_n=0 with pin_in=1 for 5 cycles -> all outputs 0; after release, level_out=1 at the 5th edge after the first sampling edge, rise_pulse high exactly 1 cycle, toggle_out=1.
- Clean rise: pin_in 0->1 sampled at edge 10 -> level_out=1 after edge 15; rise_pulse=1 only in cycle 15-16; toggle_out 0->1.
- Glitch rejection: pin_in high for 3 cycles then low -> level_out, both pulses and toggle_out remain 0 throughout; FSM returns to STABLE_LO.
- Bouncy fall: from level_out=1, pin_in alternates 0/1 every 2 cycles for 12 cycles, then holds 0 -> level_out falls exactly 5 edges after the final stable 0 is sampled; exactly one fall_pulse; toggle_out unchanged.
- Toggle: 3 clean press/release cycles -> toggle_out sequence 1,0,1; 3 rise_pulse and 3 fall_pulse.
- Reset mid-debounce: rst_n pulsed low for 1 cycle while in WAIT_HI with cnt=2 -> outputs stay 0; with pin_in still 1, level_out=1 after the full 5-edge latency measured from reset release.
- DEBOUNCE_CYCLES=1: pin_in rise sampled at edge 0 -> level_out=1 after edge 2, rise_pulse one cycle.
